// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, clock/baud constants and bit-period helper
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int CLK_HZ       = 50_000_000;
    localparam int BAUD_DEFAULT = 9600;

    // Integer division truncates: 50 MHz / 9600 -> 5208 cycles per bit.
    function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser for an asynchronous single-bit input
//
// Ports:
//   i_clk  - destination clock, rising edge
//   i_rst  - synchronous active-high reset, loads RESET_VAL into both flops
//   i_d    - asynchronous input
//   o_q    - synchronised output, two cycles of latency
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART receiver holding the last good byte for the display path
//
// Ports:
//   i_clk        - system clock, rising edge
//   i_rst        - synchronous active-high reset
//   i_rx         - asynchronous serial line, idle high
//   o_data       - last correctly framed byte, held until replaced
//   o_rx_valid   - one-cycle pulse, o_data updated this cycle
//   o_frame_err  - one-cycle pulse, stop bit sampled low, byte discarded
//   o_busy       - high whenever the receiver is not idle
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD_DEFAULT)
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_rx_valid,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);

    logic        w_rx_s;

    rx_state_t   r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_sh;
    logic [7:0]  r_data;
    logic        r_rx_valid;
    logic        r_frame_err;
    logic        r_armed;

    rx_state_t   w_state_next;
    logic [15:0] w_cnt_next;
    logic [2:0]  w_idx_next;
    logic [7:0]  w_sh_next;
    logic [7:0]  w_data_next;
    logic        w_rx_valid_next;
    logic        w_frame_err_next;
    logic        w_armed_next;

    sync2 #(.RESET_VAL(1'b1)) u_rx_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rx),
        .o_q   (w_rx_s)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_sh        <= '0;
            r_data      <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_idx       <= w_idx_next;
            r_sh        <= w_sh_next;
            r_data      <= w_data_next;
            r_rx_valid  <= w_rx_valid_next;
            r_frame_err <= w_frame_err_next;
            r_armed     <= w_armed_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_idx_next       = r_idx;
        w_sh_next        = r_sh;
        w_data_next      = r_data;
        w_rx_valid_next  = 1'b0;
        w_frame_err_next = 1'b0;
        w_armed_next     = r_armed;

        case (r_state)
            IDLE: begin
                // A start is only accepted once the line has been seen high
                // since the last frame, so a held break yields one error only.
                if (w_rx_s) begin
                    w_armed_next = 1'b1;
                end else if (r_armed) begin
                    w_state_next = START;
                    w_cnt_next   = '0;
                    w_armed_next = 1'b0;
                end
            end
            START: begin
                if (r_cnt == HALF_M1) begin
                    w_cnt_next = '0;
                    if (!w_rx_s) begin
                        w_state_next = DATA;
                        w_idx_next   = '0;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            DATA: begin
                if (r_cnt == BIT_M1) begin
                    // LSB arrives first: shift right, new bit enters at the top.
                    w_sh_next  = {w_rx_s, r_sh[7:1]};
                    w_cnt_next = '0;
                    if (r_idx == 3'd7) begin
                        w_state_next = STOP;
                    end else begin
                        w_idx_next = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            STOP: begin
                // Leave at mid-stop-bit so a back-to-back start edge is not missed.
                if (r_cnt == BIT_M1) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                    if (w_rx_s) begin
                        w_data_next     = r_sh;
                        w_rx_valid_next = 1'b1;
                    end else begin
                        w_frame_err_next = 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign o_data      = r_data;
    assign o_rx_valid  = r_rx_valid;
    assign o_frame_err = r_frame_err;
    assign o_busy      = (r_state != IDLE);

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

UART receiver front end for the display path. It deserialises 8N1 frames from the asynchronous `rx` pin into a held byte on `data[7:0]`. That byte feeds the two-digit hex display driver directly: the last good byte stays stable on `data` until the next good frame arrives. It also emits one-cycle status strobes for received bytes and framing errors.

## Interface
- `CLKS_PER_BIT`, default 5208, clock cycles per bit (50 MHz / 9600 baud); must be even and ≥ 8.
- `clk`  input  1  system clock, rising-edge.
- `rst`  input  1  synchronous, active-high reset.
- `rx`  input  1  asynchronous serial line, idle high.
- `data`  output  8  last correctly framed byte, held until replaced.
- `rx_valid`  output  1  one-cycle pulse; `data` was updated on this cycle.
- `frame_err`  output  1  one-cycle pulse; stop bit sampled low, byte discarded.
- `busy`  output  1  high whenever the state is not IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser. Both flops reset to 1. All decisions use the synchronised `rx_s`.
- State machine: IDLE, START, DATA, STOP. It uses a 16-bit cycle counter `cnt`, a 3-bit bit index `idx`, and an 8-bit shift register `sh`.
- IDLE: when `rx_s`=0, go to START with `cnt`=0.
- START: when `cnt`=CLKS_PER_BIT/2−1, check `rx_s`:
  - `rx_s`=0: go to DATA with `cnt`=0, `idx`=0.
  - `rx_s`=1: treat as a glitch and return to IDLE. No strobe is emitted.
  - Otherwise increment `cnt`.
- DATA: when `cnt`=CLKS_PER_BIT−1, shift `rx_s` into `sh` at bit 7, shifting right (LSB is received first), and clear `cnt`.
  - If `idx`=7, go to STOP; otherwise increment `idx`.
  - Otherwise increment `cnt`.
- STOP: when `cnt`=CLKS_PER_BIT−1, check `rx_s`, then go to IDLE in either case:
  - `rx_s`=1: `data`←`sh`, pulse `rx_valid`.
  - `rx_s`=0: pulse `frame_err`; `data` is unchanged.
- Returning to IDLE at mid-stop-bit allows back-to-back frames with a single stop bit.
- A break condition (line held low) produces one `frame_err`. No new frame starts until `rx_s` returns high and then falls again.
  - To guarantee this, IDLE requires `rx_s`=1 for at least one cycle after STOP before it accepts a new start. An `armed` flag is set in IDLE when `rx_s`=1.
- `rx_valid` and `frame_err` are never high in the same cycle.

## Timing
- Reset values: `data`=8'h00, `rx_valid`=0, `frame_err`=0, `busy`=0, state IDLE, `cnt`=0, `idx`=0, `sh`=0, `armed`=0.
- `rst` asserted mid-frame: the frame is abandoned and all registers take their reset values on the next edge. The partial byte is never written to `data`.
- Latency: for a falling `rx` edge setting up before clock edge E, `rx_valid` is high in the cycle following edge E + 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
  - Example: CLKS_PER_BIT=16 gives E+154.
- `data` changes only on the same edge that raises `rx_valid`.
- `busy` rises one cycle after start detection. It falls on the edge that emits the strobe, or on a START glitch abort.
- Jitter tolerance: each bit is sampled at its nominal centre ±1 cycle. Baud mismatch of up to ±4 % must still decode.

## Structure
- Shared package `uart_pkg` holds:
  - `rx_state_t` enum (IDLE, START, DATA, STOP);
  - `CLK_HZ` = 50_000_000 and `BAUD_DEFAULT` = 9600;
  - a function computing CLKS_PER_BIT from these.
- Sub-module `sync2`: a parameterisable-reset-value 2-flop synchroniser, reusable for other async inputs.
- The FSM, counter and shift register stay in `uart_rx_byte`.

## Test plan
- Single frame, CLKS_PER_BIT=16, byte 8'hA5 → exactly one `rx_valid` pulse at E+154; `data`=8'hA5; `frame_err` stays 0.
- Back-to-back frames 8'h3C then 8'hF0 with one stop bit and no idle gap → two `rx_valid` pulses 160 cycles apart; `data` ends at 8'hF0.
- Frame 8'h55 with stop bit forced low → one `frame_err` pulse, no `rx_valid`; `data` keeps the previous value 8'hA5.
- 3-cycle low glitch on idle `rx` → no strobes; `busy` high for ≤ 9 cycles, then IDLE; a following valid 8'h12 frame decodes correctly.
- `rst` pulsed at bit 4 of a frame carrying 8'hFF → next cycle `data`=8'h00 and `busy`=0. Remaining bits produce no strobe while `rx` stays high; the next 8'h81 frame decodes.
- Baud skew: transmit 8'hC3 at 1.04× and 0.96× the nominal bit period → `data`=8'hC3 with no `frame_err` in both cases.
